matmul_pad_top: RTL and testbench
=================================

// Module: matmul_pad_top
// PURPOSE
//  Chip-level matrix-multiply accelerator behind the pad ring. Streams in an 8x4 matrix X of 8-bit unsigned bytes and
//  computes R = A*X (4x4, 18-bit unsigned), where A is a fixed 4x8 coefficient ROM.
//  Results go to an internal result RAM, which is read back 9 bits at a time through the pads.
// PARAMETERS
//  MATRIX_NUM  2   number of X matrices buffered; result RAM depth = MATRIX_NUM*16 words of 18 bits
//  NUM_MAC     4   parallel MAC units; one per result column j
// PORTS
//  clk_pad          in   1  the single clock; all logic on its rising edge
//  rst_pad          in   1  reset; asynchronous, active-low
//  start_in_pad     in   1  start request; sampled in IDLE
//  valid_input_pad  in   1  X_load_pad carries a valid byte this cycle
//  X_load_pad       in   8  X element, unsigned
//  read_n_pad       in   1  active-low read request for the result RAM
//  r_addr_pad       in   8  result RAM word address (matrix m, element e -> m*16+e)
//  ry_pad           out  1  read data valid
//  read_data_pad    out  9  result half-word: low half [8:0] first, then high half [17:9]
//  finish_pad       out  1  current matrix computed and stored
// BEHAVIOUR
//  Reset: FSM=IDLE; load count, matrix index, MAC accumulators, ry_pad, read_data_pad and finish_pad all 0.
//    Result RAM contents are not cleared.
//  FSM IDLE -> LOAD when start_in_pad=1 at a clock edge; finish_pad clears on the same edge.
//  LOAD: each edge with valid_input_pad=1 stores X_load_pad at index n (0..31, arrival order).
//    valid_input_pad=0 pauses loading; the count holds. Storage is row-major: X[k][j] = byte n, n = 4k+j, k 0..7, j 0..3.
//    After the 32nd byte, go to COMPUTE.
//  COMPUTE: for row i = 0..3, MAC j accumulates A[i][k]*X[k][j] over k = 0..7, one k per cycle.
//    That is 8 cycles per row, 32 cycles total.
//    At the end of each row, write R[i][j] to address m*16 + i*4 + j for all four j; then clear the accumulators.
//  Arithmetic: A is 7-bit unsigned, X is 8-bit unsigned, products are 15-bit, sums are 18-bit.
//    Maximum 8*255*127 = 259080 fits in 18 bits, so no overflow or saturation logic.
//  DONE: after the last row write, finish_pad=1 (level).
//    finish_pad stays high until the next start is accepted. The matrix index m increments and wraps MATRIX_NUM-1 -> 0.
//    Return to IDLE.
//  start_in_pad in LOAD or COMPUTE is ignored. Extra valid bytes outside LOAD are ignored.
//  Read port, independent of the FSM and legal at any time:
//    edge E samples read_n_pad=0 and latches r_addr_pad.
//    After E+1: read_data_pad = R[8:0], ry_pad=1.
//    After E+2: read_data_pad = R[17:9], ry_pad=1.
//    After E+3: ry_pad=0; read_data_pad holds the high half.
//    A read_n_pad=0 during an active read restarts the read at the new address.
//    Addresses >= MATRIX_NUM*16 return 0.
//  Default ROM: A[i][k] = 8*i + k + 1, giving values 1..32.
//  Reset mid-operation aborts any load, compute or read and returns to IDLE with m=0.
//    Partially written RAM words stay as written.
// CONFIGURATION
//  COEF_FILE_EN defined: the A ROM is initialised with $readmemb("coef.txt"); 32 binary 7-bit words, index 8*i+k.
//  COEF_FILE_EN undefined: the ROM uses the formula A[i][k] = 8*i + k + 1. No file access.
// TESTING
//  1 Reset: hold rst_pad=0 -> ry_pad=0, finish_pad=0, read_data_pad=0. Release; no activity until start.
//  2 Start, then 32 bytes all = 1 -> finish_pad rises within 40 cycles of the last byte.
//    Expect R[i][j] = 64i+36, so addr0 = 36, addr4 = 100, addr8 = 164, addr12 = 228.
//  3 Full scale: all X = 255 (default ROM) -> addr12 = 58140.
//    Read returns low half 284, then high half 113. ry_pad is high exactly 2 cycles.
//  4 Two matrices: first all = 1, second all = 2 (start after finish) -> addr16 = 72, addr28 = 456.
//    addr0 still reads 36; after the second finish, m wraps to 0.
//  5 Pause: drop valid_input_pad for 5 cycles mid-load -> results are identical to scenario 2.
//    Extra start_in pulses during LOAD are ignored.
//  6 Reset asserted during COMPUTE -> finish_pad stays 0. A fresh start then writes from addr0 again.

Source files
------------

// File: rtl/matmul_pad_top.sv
// matmul_pad_top: R = A*X for a 4x8 coefficient ROM and a streamed 8x4 byte matrix.
// The ROM holds A[i][k] = 8*i+k+1.
module matmul_pad_top #(
  parameter int MATRIX_NUM = 2,
  parameter int NUM_MAC    = 4
) (
  input  logic       clk_pad,
  input  logic       rst_pad,
  input  logic       start_in_pad,
  input  logic       valid_input_pad,
  input  logic [7:0] X_load_pad,
  input  logic       read_n_pad,
  input  logic [7:0] r_addr_pad,
  output logic       ry_pad,
  output logic [8:0] read_data_pad,
  output logic       finish_pad
);
  localparam int DEPTH = MATRIX_NUM * 16;
  localparam int AW = $clog2(DEPTH);
  localparam int MW = (MATRIX_NUM > 1) ? $clog2(MATRIX_NUM) : 1;
  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]    x_mem [32];
  logic [17:0]   ram [DEPTH];
  logic [17:0]   acc [NUM_MAC];
  logic [14:0]   prod [NUM_MAC];
  logic [17:0]   sum [NUM_MAC];
  logic [4:0]    n;
  logic [1:0]    row;
  logic [2:0]    k;
  logic [MW-1:0] m;
  logic [6:0]    a_cur;
  logic [AW-1:0] wbase;

  assign a_cur = 7'({row, k}) + 7'd1;

  assign wbase = AW'(int'(m) * 16 + int'(row) * 4);

  always_comb begin
    for (int j = 0; j < NUM_MAC; j++) begin
      prod[j] = 15'(a_cur) * 15'(x_mem[{k, 2'(j)}]);
      sum[j]  = acc[j] + 18'(prod[j]);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_in_pad) state_nx = LOAD;
      LOAD:    if (valid_input_pad && n == 5'd31) state_nx = COMPUTE;
      COMPUTE: if (row == 2'd3 && k == 3'd7) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pad or negedge rst_pad) begin
    if (!rst_pad) begin
      state      <= IDLE;
      n          <= '0;
      row        <= '0;
      k          <= '0;
      m          <= '0;
      finish_pad <= 1'b0;
      for (int j = 0; j < NUM_MAC; j++) acc[j] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start_in_pad) begin
          finish_pad <= 1'b0;
          n          <= '0;
          row        <= '0;
          k          <= '0;
        end
        LOAD: if (valid_input_pad) n <= n + 5'd1;
        COMPUTE: begin
          k <= k + 3'd1;
          if (k == 3'd7) row <= row + 2'd1;
          // accumulators restart at the row boundary
          for (int j = 0; j < NUM_MAC; j++)
            acc[j] <= (k == 3'd7) ? '0 : sum[j];
        end
        DONE: begin
          finish_pad <= 1'b1;
          m <= (m == MW'(MATRIX_NUM - 1)) ? '0 : m + MW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pad) begin
    if (state == LOAD && valid_input_pad) x_mem[n] <= X_load_pad;
    if (state == COMPUTE && k == 3'd7)
      for (int j = 0; j < NUM_MAC; j++) ram[wbase + AW'(j)] <= sum[j];
  end

  logic [7:0]  rd_addr;
  logic [1:0]  rd_ph;
  logic [8:0]  rd_hi;
  logic [17:0] rd_word;

  assign rd_word = ({1'b0, rd_addr} < DEPTH9) ? ram[rd_addr[AW-1:0]] : '0;

  always_ff @(posedge clk_pad or negedge rst_pad) begin
    if (!rst_pad) begin
      rd_addr       <= '0;
      rd_ph         <= '0;
      rd_hi         <= '0;
      ry_pad        <= 1'b0;
      read_data_pad <= '0;
    end else if (!read_n_pad) begin
      rd_addr <= r_addr_pad;
      rd_ph   <= 2'd1;
      ry_pad  <= 1'b0;
    end else begin
      unique case (rd_ph)
        2'd1: begin
          read_data_pad <= rd_word[8:0];
          rd_hi         <= rd_word[17:9];
          ry_pad        <= 1'b1;
          rd_ph         <= 2'd2;
        end
        2'd2: begin
          read_data_pad <= rd_hi;
          ry_pad        <= 1'b1;
          rd_ph         <= 2'd3;
        end
        2'd3: begin
          ry_pad <= 1'b0;
          rd_ph  <= 2'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_pad_top.sv
// Scoreboard bench for matmul_pad_top: a plain-arithmetic R = A*X model feeds
// expected read words into a queue that a monitor drains as ry_pad pulses arrive.
module tb_matmul_pad_top;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] xin = '0;
  logic       rn = 1'b1;
  logic [7:0] ra = '0;
  logic       ry;
  logic [8:0] rdata;
  logic       fin;

  always #5 clk = ~clk;

  matmul_pad_top dut (
    .clk_pad(clk), .rst_pad(rst), .start_in_pad(start),
    .valid_input_pad(valid), .X_load_pad(xin), .read_n_pad(rn),
    .r_addr_pad(ra), .ry_pad(ry), .read_data_pad(rdata),
    .finish_pad(fin)
  );

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int ref_ram [32];
  int mi = 0;
  logic [7:0] xbuf [32];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic monitor();
    int cnt = 0;
    int lo = 0;
    int hi = 0;
    forever begin
      @(negedge clk);
      if (ry) begin
        if (cnt == 0) lo = int'(rdata);
        else hi = int'(rdata);
        cnt++;
      end else if (cnt != 0) begin
        chk("ry_width", cnt, 2);
        if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
        else chk("read_word", hi * 512 + lo, exp_q.pop_front());
        cnt = 0;
      end
    end
  endtask

  function automatic int coef(int i, int k);
    return 8 * i + k + 1;
  endfunction

  task automatic model_update();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 8; k++) s += coef(i, k) * int'(xbuf[4 * k + j]);
        ref_ram[mi * 16 + 4 * i + j] = s;
      end
    mi = (mi + 1) % 2;
  endtask

  task automatic fill(input int v);
    for (int n = 0; n < 32; n++)
      xbuf[n] = (v < 0) ? 8'($urandom) : 8'(v);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("finish_clear_on_start", int'(fin), 0);
  endtask

  task automatic load(input bit pause, input bit xstart);
    for (int n = 0; n < 32; n++) begin
      if (pause && n == 16) begin
        valid = 1'b0;
        repeat (5) @(negedge clk);
      end
      valid = 1'b1;
      xin = xbuf[n];
      start = xstart && (n == 10 || n == 20);
      @(negedge clk);
    end
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string nm);
    int c = 0;
    while (!fin && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk(nm, int'(fin), 1);
  endtask

  task automatic run(input bit pause, input bit xstart, input bit junk);
    do_start();
    load(pause, xstart);
    if (junk) begin
      for (int t = 0; t < 3; t++) begin
        valid = 1'b1;
        xin = 8'($urandom);
        @(negedge clk);
      end
      valid = 1'b0;
    end
    wait_finish("finish_timeout");
    model_update();
  endtask

  task automatic rd_exp(input int addr, input int exp);
    exp_q.push_back(exp);
    rn = 1'b0;
    ra = 8'(addr);
    @(negedge clk);
    rn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(input int addr);
    rd_exp(addr, (addr < 32) ? ref_ram[addr] : 0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_ry", int'(ry), 0);
    chk("reset_finish", int'(fin), 0);
    chk("reset_data", int'(rdata), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_finish", int'(fin), 0);
    chk("idle_ry", int'(ry), 0);

    fill(1);
    run(1'b0, 1'b0, 1'b0);
    rd_exp(0, 36);
    rd_exp(4, 100);
    rd_exp(8, 164);
    rd_exp(12, 228);
    chk("finish_level", int'(fin), 1);

    fill(255);
    run(1'b0, 1'b0, 1'b0);
    rd_exp(28, 58140);
    rd(16);

    fill(1);
    run(1'b0, 1'b0, 1'b0);
    fill(2);
    run(1'b0, 1'b0, 1'b0);
    rd_exp(16, 72);
    rd_exp(28, 456);
    rd_exp(0, 36);

    fill(1);
    run(1'b1, 1'b1, 1'b1);
    rd_exp(0, 36);
    rd_exp(12, 228);
    rd_exp(5, 100);

    fill(-1);
    run(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) rd(16 + int'($urandom_range(0, 15)));

    fill(-1);
    do_start();
    load(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_finish", int'(fin), 0);
    chk("abort_ry", int'(ry), 0);
    @(negedge clk);
    rst = 1'b1;
    mi = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_finish", int'(fin), 0);
    rd(0);

    fill(-1);
    run(1'b0, 1'b0, 1'b0);
    rd(0);
    rd(15);
    rd(int'($urandom_range(1, 14)));
    rd(32);
    rd(200);

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
